// File: rtl/cv32e40p_pkg.sv
// Shared types and helpers for the triplicated interrupt path voter.
package cv32e40p_pkg;

    // Per-replica fault monitor states.
    typedef enum logic [1:0] {
        TMR_OK      = 2'd0,
        TMR_SUSPECT = 2'd1,
        TMR_FAULTY  = 2'd2
    } tmr_state_e;

    // Width of the voted vector {req, sec, id[4:0], wu, mip[31:0]}.
    localparam int unsigned IRQ_TMR_W = 40;

    // Bitwise 2-of-3 majority across the three replica vectors.
    function automatic logic [IRQ_TMR_W-1:0] tmr_majority(
        input logic [IRQ_TMR_W-1:0] a,
        input logic [IRQ_TMR_W-1:0] b,
        input logic [IRQ_TMR_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/cv32e40p_tmr_fault_fsm.sv
// Per-replica fault monitor: separates transient upsets from persistent
// faults by counting consecutive mismatching cycles. FAULTY is sticky
// until clear_i or reset.
module cv32e40p_tmr_fault_fsm
    import cv32e40p_pkg::*;
#(
    parameter int unsigned FAULT_THRESHOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic mm_i,
    output logic faulty_o
);

    localparam logic [3:0] THRESH = FAULT_THRESHOLD[3:0];

    tmr_state_e state_r;
    tmr_state_e state_nxt_s;
    logic [3:0] consec_r;
    logic [3:0] consec_nxt_s;

    // State and consecutive-mismatch count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= TMR_OK;
            consec_r <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            consec_r <= consec_nxt_s;
        end
    end

    // Next-state logic; clear_i overrides any mismatch seen in the same cycle.
    always_comb begin
        state_nxt_s  = state_r;
        consec_nxt_s = consec_r;
        if (clear_i) begin
            state_nxt_s  = TMR_OK;
            consec_nxt_s = 4'd0;
        end else begin
            case (state_r)
                TMR_OK: begin
                    if (mm_i) begin
                        consec_nxt_s = 4'd1;
                        state_nxt_s  = (THRESH <= 4'd1) ? TMR_FAULTY : TMR_SUSPECT;
                    end else begin
                        consec_nxt_s = 4'd0;
                        state_nxt_s  = TMR_OK;
                    end
                end
                TMR_SUSPECT: begin
                    if (mm_i) begin
                        consec_nxt_s = consec_r + 4'd1;
                        if ((consec_r + 4'd1) >= THRESH) begin
                            state_nxt_s = TMR_FAULTY;
                        end else begin
                            state_nxt_s = TMR_SUSPECT;
                        end
                    end else begin
                        // A single matching cycle wipes out the streak.
                        consec_nxt_s = 4'd0;
                        state_nxt_s  = TMR_OK;
                    end
                end
                TMR_FAULTY: begin
                    state_nxt_s  = TMR_FAULTY;
                    consec_nxt_s = consec_r;
                end
                default: begin
                    state_nxt_s  = TMR_OK;
                    consec_nxt_s = 4'd0;
                end
            endcase
        end
    end

    assign faulty_o = (state_r == TMR_FAULTY);

endmodule

// File: rtl/cv32e40p_int_tmr_voter.sv
// Majority voter for the triplicated interrupt-controller outputs. The vote
// is purely combinational; fault monitoring and statistics are observability
// only and never influence the voted value.
module cv32e40p_int_tmr_voter
    import cv32e40p_pkg::*;
#(
    parameter int unsigned FAULT_THRESHOLD = 4,
    parameter int unsigned CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 irq_req_ctrl_i_1,
    input  logic                 irq_req_ctrl_i_2,
    input  logic                 irq_req_ctrl_i_3,
    input  logic                 irq_sec_ctrl_i_1,
    input  logic                 irq_sec_ctrl_i_2,
    input  logic                 irq_sec_ctrl_i_3,
    input  logic [4:0]           irq_id_ctrl_i_1,
    input  logic [4:0]           irq_id_ctrl_i_2,
    input  logic [4:0]           irq_id_ctrl_i_3,
    input  logic                 irq_wu_ctrl_i_1,
    input  logic                 irq_wu_ctrl_i_2,
    input  logic                 irq_wu_ctrl_i_3,
    input  logic [31:0]          mip_i_1,
    input  logic [31:0]          mip_i_2,
    input  logic [31:0]          mip_i_3,
    input  logic                 clear_i,
    output logic                 irq_req_ctrl_o,
    output logic                 irq_sec_ctrl_o,
    output logic [4:0]           irq_id_ctrl_o,
    output logic                 irq_wu_ctrl_o,
    output logic [31:0]          mip_o,
    output logic                 err_o,
    output logic                 uncorr_o,
    output logic [2:0]           fault_o,
    output logic [CNT_WIDTH-1:0] mismatch_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [IRQ_TMR_W-1:0] vec_1_s;
    logic [IRQ_TMR_W-1:0] vec_2_s;
    logic [IRQ_TMR_W-1:0] vec_3_s;
    logic [IRQ_TMR_W-1:0] voted_s;
    logic [2:0]           mm_s;
    logic                 any_mm_s;
    logic                 all_mm_s;
    logic                 err_r;
    logic                 uncorr_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;

    assign vec_1_s = {irq_req_ctrl_i_1, irq_sec_ctrl_i_1, irq_id_ctrl_i_1, irq_wu_ctrl_i_1, mip_i_1};
    assign vec_2_s = {irq_req_ctrl_i_2, irq_sec_ctrl_i_2, irq_id_ctrl_i_2, irq_wu_ctrl_i_2, mip_i_2};
    assign vec_3_s = {irq_req_ctrl_i_3, irq_sec_ctrl_i_3, irq_id_ctrl_i_3, irq_wu_ctrl_i_3, mip_i_3};

    assign voted_s = tmr_majority(vec_1_s, vec_2_s, vec_3_s);
    assign {irq_req_ctrl_o, irq_sec_ctrl_o, irq_id_ctrl_o, irq_wu_ctrl_o, mip_o} = voted_s;

    // A replica disagrees when its whole vector differs from the voted word.
    assign mm_s[0]  = (vec_1_s != voted_s);
    assign mm_s[1]  = (vec_2_s != voted_s);
    assign mm_s[2]  = (vec_3_s != voted_s);
    assign any_mm_s = |mm_s;
    assign all_mm_s = &mm_s;

    // Saturating mismatch-event counter, next value.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear_i) begin
            cnt_nxt_s = {CNT_WIDTH{1'b0}};
        end else if (any_mm_s && (cnt_r != CNT_MAX)) begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Error flags and counter registers; clear_i discards this cycle's events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r    <= 1'b0;
            uncorr_r <= 1'b0;
            cnt_r    <= {CNT_WIDTH{1'b0}};
        end else if (clear_i) begin
            err_r    <= 1'b0;
            uncorr_r <= 1'b0;
            cnt_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            err_r    <= any_mm_s;
            uncorr_r <= all_mm_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign err_o          = err_r;
    assign uncorr_o       = uncorr_r;
    assign mismatch_cnt_o = cnt_r;

    for (genvar k = 0; k < 3; k++) begin : g_fsm
        cv32e40p_tmr_fault_fsm #(
            .FAULT_THRESHOLD(FAULT_THRESHOLD)
        ) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (clear_i),
            .mm_i    (mm_s[k]),
            .faulty_o(fault_o[k])
        );
    end

endmodule
